// File: rtl/sram_wrapper_pkg.sv
// Shared types and constants for the lane-addressed banked SRAM wrapper.
// Latency and FIFO depth are derived from the output-register option.
package sram_wrapper_pkg;

  localparam int DEFAULT_LANE_W = 8;

  typedef logic [DEFAULT_LANE_W-1:0] lane_t;

  // Lane 0 is the most-significant lane of the word.
  function automatic int lane_lsb(input int lane, input int lane_w, input int num_lanes);
    return (num_lanes - 1 - lane) * lane_w;
  endfunction

  function automatic int read_latency(input int out_reg);
    return 2 + out_reg;
  endfunction

  function automatic int fifo_depth(input int out_reg);
    return read_latency(out_reg) + 1;
  endfunction

endpackage

// File: rtl/sram_bank_model.sv
// Behavioural single-port SRAM bank: active-low CSN/WEN, per-lane write
// enables and a registered read port that holds Q when not reading.
module sram_bank_model
  import sram_wrapper_pkg::*;
#(
  parameter int ROWS      = 2048,
  parameter int ROW_W     = 11,
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 8
) (
  input  logic                        clk,
  input  logic                        csn,
  input  logic                        wen,
  input  logic [NUM_LANES-1:0]        lane_we,
  input  logic [ROW_W-1:0]            addr,
  input  logic [NUM_LANES*LANE_W-1:0] d,
  output logic [NUM_LANES*LANE_W-1:0] q
);

  logic [NUM_LANES*LANE_W-1:0] mem [ROWS];

  // NOTE: the array models a macro, so it has no reset; its contents survive
  // wrapper reset and power up undefined.
  always_ff @(posedge clk) begin
    if (!csn) begin
      if (!wen) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (lane_we[i]) begin
            mem[addr][lane_lsb(i, LANE_W, NUM_LANES) +: LANE_W] <= d[lane_lsb(i, LANE_W, NUM_LANES) +: LANE_W];
          end
        end
      end else begin
        q <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sram_lane_bank_wrapper.sv
// Word-addressed SRAM built from NUM_BANKS macro banks with lane write masks,
// a valid/ready request port and an in-order credit-limited response FIFO.
module sram_lane_bank_wrapper
  import sram_wrapper_pkg::*;
#(
  parameter int NUM_WORDS = 4096,
  parameter int NUM_BANKS = 2,
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 8,
  parameter int OUT_REG   = 0,
  parameter int ADDR_W    = $clog2(NUM_WORDS)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [NUM_LANES-1:0]        req_lane_en,
  input  logic [NUM_LANES*LANE_W-1:0] req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [NUM_LANES*LANE_W-1:0] rsp_rdata
);

  localparam int WORD_W = NUM_LANES * LANE_W;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int ROW_W  = ADDR_W - $clog2(NUM_BANKS);
  localparam int ROWS   = NUM_WORDS / NUM_BANKS;
  localparam int DEPTH  = fifo_depth(OUT_REG);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              accept, rd_accept, pop;
  logic [BANK_W-1:0] bank_idx;
  logic [ROW_W-1:0]  row;
  logic [NUM_BANKS-1:0] bank_csn;
  logic [WORD_W-1:0] bank_q [NUM_BANKS];

  logic              s1_valid;
  logic [BANK_W-1:0] s1_bank;
  logic              push_valid;
  logic [WORD_W-1:0] push_data;

  logic [WORD_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt, cnt, cnt_next;

  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;
  assign pop       = rsp_valid && rsp_ready;
  assign row       = req_addr[ROW_W-1:0];

  generate
    if (NUM_BANKS > 1) begin : g_bank_dec
      assign bank_idx = req_addr[ADDR_W-1 -: BANK_W];
    end else begin : g_single_bank
      assign bank_idx = '0;
    end
  endgenerate

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    bank_csn = '1;
    if (accept) bank_csn[bank_idx] = 1'b0;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sram_bank_model #(
      .ROWS(ROWS), .ROW_W(ROW_W), .NUM_LANES(NUM_LANES), .LANE_W(LANE_W)
    ) u_bank (
      .clk(CLK), .csn(bank_csn[b]), .wen(!req_we), .lane_we(req_lane_en),
      .addr(row), .d(req_wdata), .q(bank_q[b])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_bank  <= '0;
    end else begin
      s1_valid <= rd_accept;
      s1_bank  <= bank_idx;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              s2_valid;
      logic [WORD_W-1:0] s2_data;
      always_ff @(posedge CLK) begin
        if (RST) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= bank_q[s1_bank];
        end
      end
      assign push_valid = s2_valid;
      assign push_data  = s2_data;
    end else begin : g_no_out_reg
      assign push_valid = s1_valid;
      assign push_data  = bank_q[s1_bank];
    end
  endgenerate

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge CLK) begin
    if (push_valid) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_valid) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)        rd_ptr <= ptr_inc(rd_ptr);
      if (push_valid && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push_valid && pop) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // Credits cover reads still in the pipeline, so the FIFO can never overflow.
  always_comb begin
    cnt_next = cnt;
    if (rd_accept && !pop)      cnt_next = cnt + 1'b1;
    else if (!rd_accept && pop) cnt_next = cnt - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt <= '0;
    else     cnt <= cnt_next;
  end

  assign req_ready = !RST && (cnt < CNT_W'(DEPTH));
  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_rdata = rsp_valid ? fifo_mem[rd_ptr] : '0;

endmodule

// File: doc/sram_lane_bank_wrapper.md
# sram_lane_bank_wrapper

Parametrised successor to the fixed 4096x32 lane wrapper. It builds one logical word-addressed SRAM from NUM_BANKS behavioural macro banks and adds per-lane write enables. Requests use a valid/ready port; read responses use a valid/ready port with an in-order response FIFO and optional output register. It sits between accelerator datapath masters (weight and activation fetch) and on-chip memory, and returns lane-split read data.

## Interface
Parameters:
- NUM_WORDS, 4096, total logical words; power of two, and a multiple of NUM_BANKS.
- NUM_BANKS, 2, physical banks; power of two ≥1. The bank is selected by the address MSBs.
- NUM_LANES, 4, lanes per word.
- LANE_W, 8, bits per lane. WORD_W = NUM_LANES*LANE_W.
- OUT_REG, 0, 1 adds a read output register stage.
- ADDR_W, $clog2(NUM_WORDS), derived.

Ports:
- CLK  in  1  Clock.
- RST  in  1  Reset: **one clock; reset is synchronous and active-high.**
- req_valid  in  1  Request valid.
- req_ready  out  1  Request ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  Word address.
- req_lane_en  in  NUM_LANES  Write lane mask; bit i = lane i. Ignored on reads.
- req_wdata  in  WORD_W  Write data.
- rsp_valid  out  1  Read data valid.
- rsp_ready  in  1  Read data accepted.
- rsp_rdata  out  WORD_W  Read data.

Lane mapping applies to req_wdata and rsp_rdata: lane i occupies bits [WORD_W-1-i*LANE_W -: LANE_W], so lane 0 is the MS lane.

## Operation
- A request is accepted on any edge with req_valid & req_ready.
- **Write:** in the selected bank, lanes with req_lane_en=1 take req_wdata. Other lanes are unchanged. A mask of all zeros is a no-op write. Writes produce no response.
- **Read:** the word is captured into the response FIFO and returned in request order.
- **Bank decode:** bank = addr[ADDR_W-1 -: log2(NUM_BANKS)] and row = the remaining bits. Only the selected bank gets chip-enable (power). The read mux uses the bank index registered with the read.
- **Latency constant:** L = 2+OUT_REG. FIFO depth D = L+1.
- **Outstanding counter cnt** (reads in flight plus reads in the FIFO):
  - +1 on read accept.
  - −1 on rsp_valid & rsp_ready.
  - Both events in the same cycle leave cnt unchanged.
- **req_ready = !RST && cnt < D.** This applies to reads and writes alike. It is registered-path only and has no combinational dependence on rsp_ready or req_valid.
- **Read-after-write:** a read accepted the cycle after a write to the same address returns the new data.
- **Reset:** clears cnt, the FIFO, the in-flight pipeline and the output register. Memory contents are retained and are not initialised. Reads in flight during reset are discarded and are never returned.

## Timing
- A read accepted on edge t gives rsp_valid at cycle t+L, provided the FIFO ahead of it is empty and no earlier response is stalled.
- With rsp_ready held high, back-to-back reads sustain 1 response/cycle and req_ready stays high.
- **rsp_ready low:** at most D reads are outstanding, then req_ready drops. rsp_rdata is held stable while rsp_valid & !rsp_ready.
- **Reset values:**
  - req_ready=0 during RST and 1 in the first cycle after.
  - rsp_valid=0.
  - rsp_rdata=0.
- **Write visibility:** a write on edge t is visible to a read accepted on edge t+1 or later.

## Structure
- **Package sram_wrapper_pkg** holds:
  - lane_t (logic [LANE_W-1:0]).
  - The lane-index helper function (lane i → bit slice).
  - Constants L and D as functions of OUT_REG.
- **Sub-module sram_bank_model:** one behavioural single-port bank with CSN, WEN, per-lane write enable and a 1-cycle registered Q. It is instantiated NUM_BANKS times via generate.
- **Top level:** decode, in-flight shift register (valid + bank index), optional output register, response FIFO and credit counter.

## Test plan
- **Full write then read:** write addr 5 = 0xDEADBEEF, mask 4'b1111, then read addr 5 → rsp_rdata=0xDEADBEEF at t+2 (OUT_REG=0) and at t+3 (OUT_REG=1).
- **Lane mask:** over 0xDEADBEEF, write 0x11223344 with mask 4'b0100 (lane 2) → read returns 0xDEAD33EF. Mask 4'b0000 → unchanged.
- **Bank boundary:** NUM_BANKS=2, write addr 2047=0xA5A5A5A5 and addr 2048=0x5A5A5A5A → each reads back its own value. Only one bank's CSN is low per access.
- **Throughput:** 8 back-to-back reads with rsp_ready=1 → req_ready never drops and 8 consecutive in-order rsp_valid cycles start at cycle 2.
- **Backpressure:** rsp_ready=0, issue reads (OUT_REG=0) → exactly 3 accepted, then req_ready=0 and rsp_rdata stable. Raise rsp_ready → 3 responses in order, then req_ready returns.
- **Reset mid-burst:** assert RST one cycle with 2 reads in flight → no rsp_valid afterwards, cnt=0, and previously written data is still readable.
